// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame decoder
// and the command dispatcher that consumes its frames.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        PAYLOAD,
        CHK,
        HOLD
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_MOVE   = 8'h10;
    localparam logic [7:0] CMD_STOP   = 8'h7F;

endpackage

// File: rtl/uart_payload_buf.sv
// Payload register file: one write port, one registered read port.
// Storage is not reset; only the read register is.
module uart_payload_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 8'h00;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_frame_decoder.sv
// Assembles SYNC/CMD/LEN/payload/CHK frames from a UART byte stream
// and holds one checked frame for the dispatcher.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int         MAX_PAYLOAD    = 16,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    input  logic          rx_endofpacket,
    output logic          frame_valid,
    input  logic          frame_ready,
    output logic [7:0]    frame_cmd,
    output logic [7:0]    frame_len,
    input  logic [AW-1:0] pl_addr,
    output logic [7:0]    pl_data,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_abort,
    output logic          err_drop
);

    localparam logic [7:0]  MAXP8 = 8'(MAX_PAYLOAD);
    localparam logic [31:0] TMO32 = 32'(TIMEOUT_CYCLES);

    state_e      r_state;
    logic        r_frame_valid;
    logic [7:0]  r_cmd;
    logic [7:0]  r_len;
    logic [7:0]  r_chk;
    logic [7:0]  r_idx;
    logic [31:0] r_tmo;
    logic        r_err_chk;
    logic        r_err_len;
    logic        r_err_abort;
    logic        r_err_drop;

    logic        w_we;
    logic        w_done;
    logic        w_tmo_hit;

    assign w_we      = (r_state == PAYLOAD) && rx_valid;
    assign w_done    = (r_state == CHK) && (rx_data == r_chk);
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo == TMO32);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_frame_valid <= 1'b0;
            r_cmd         <= 8'h00;
            r_len         <= 8'h00;
            r_chk         <= 8'h00;
            r_idx         <= 8'h00;
            r_tmo         <= 32'd0;
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_abort   <= 1'b0;
            r_err_drop    <= 1'b0;
        end else begin
            r_err_chk   <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_abort <= 1'b0;
            r_err_drop  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_tmo <= 32'd0;
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        r_state <= CMD;
                    end
                end
                HOLD: begin
                    r_tmo <= 32'd0;
                    if (rx_valid) begin
                        r_err_drop <= 1'b1;
                    end
                    if (r_frame_valid && frame_ready) begin
                        r_frame_valid <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        r_tmo <= 32'd0;
                        unique case (r_state)
                            CMD: begin
                                r_cmd   <= rx_data;
                                r_chk   <= rx_data;
                                r_state <= LEN;
                            end
                            LEN: begin
                                if (rx_data > MAXP8) begin
                                    r_err_len <= 1'b1;
                                    r_state   <= IDLE;
                                end else begin
                                    r_len   <= rx_data;
                                    r_chk   <= r_chk ^ rx_data;
                                    r_idx   <= 8'h00;
                                    r_state <= (rx_data == 8'h00) ? CHK : PAYLOAD;
                                end
                            end
                            PAYLOAD: begin
                                r_chk <= r_chk ^ rx_data;
                                r_idx <= r_idx + 8'd1;
                                if (r_idx == r_len - 8'd1) begin
                                    r_state <= CHK;
                                end
                            end
                            CHK: begin
                                if (w_done) begin
                                    r_frame_valid <= 1'b1;
                                    r_state       <= HOLD;
                                end else begin
                                    r_err_chk <= 1'b1;
                                    r_state   <= IDLE;
                                end
                            end
                            default: ;
                        endcase
                        // A byte that closes the frame wins over a coincident idle gap
                        if (rx_endofpacket && !w_done) begin
                            r_err_abort <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end else if (rx_endofpacket || w_tmo_hit) begin
                        r_err_abort <= 1'b1;
                        r_state     <= IDLE;
                    end else if (r_tmo != '1) begin
                        r_tmo <= r_tmo + 32'd1;
                    end
                end
            endcase
        end
    end

    uart_payload_buf #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (r_idx[AW-1:0]),
        .i_wdata (rx_data),
        .i_raddr (pl_addr),
        .o_rdata (pl_data)
    );

    assign frame_valid = r_frame_valid;
    assign frame_cmd   = r_cmd;
    assign frame_len   = r_len;
    assign err_chk     = r_err_chk;
    assign err_len     = r_err_len;
    assign err_abort   = r_err_abort;
    assign err_drop    = r_err_drop;

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
- Consumes the byte stream from the UART receiver and assembles framed robot command packets: SYNC, CMD, LEN, payload, CHK.
- Validates length and checksum, then presents one complete frame to the command dispatcher through a valid/ready handshake. Payload is read back through a random-access port.
- Aborts partial frames on a receiver idle gap or an inter-byte timeout.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-frame marker
- MAX_PAYLOAD, 16, maximum payload bytes; must be ≥1 and ≤255
- TIMEOUT_CYCLES, 50000, clk cycles allowed between bytes inside a frame; 0 disables the timeout
- AW, $clog2(MAX_PAYLOAD), payload address width

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- rx_data, in, 8, received byte; valid only while rx_valid=1
- rx_valid, in, 1, one-cycle strobe per received byte
- rx_endofpacket, in, 1, one-cycle strobe when the receiver line goes idle
- frame_valid, out, 1, complete, checked frame available
- frame_ready, in, 1, consumer accepts the frame
- frame_cmd, out, 8, command byte of the held frame
- frame_len, out, 8, payload length of the held frame
- pl_addr, in, AW, payload read address
- pl_data, out, 8, payload byte at pl_addr; registered, 1-cycle read latency
- err_chk, out, 1, one-cycle pulse on checksum mismatch
- err_len, out, 1, one-cycle pulse when LEN > MAX_PAYLOAD
- err_abort, out, 1, one-cycle pulse on gap/timeout abort of a partial frame
- err_drop, out, 1, one-cycle pulse for each byte dropped while a frame is held

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE; frame_valid=0; frame_cmd=0; frame_len=0; pl_data=0; all err_* = 0; checksum=0; index=0; timeout counter=0.
- States: IDLE, CMD, LEN, PAYLOAD, CHK, HOLD.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE → CMD.
  - Any other byte is ignored silently.
- CMD: on a byte, latch cmd, set chk=byte, → LEN.
- LEN: on a byte:
  - If byte > MAX_PAYLOAD: pulse err_len, → IDLE.
  - Otherwise latch len, set chk ^= byte, set index=0, then → PAYLOAD if len≠0, else → CHK.
- PAYLOAD: on a byte:
  - Write the byte to buffer[index], set chk ^= byte, index++.
  - When index==len-1 is written → CHK.
- CHK: on a byte:
  - If byte==chk: → HOLD, and frame_valid rises the next cycle.
  - Otherwise: pulse err_chk, → IDLE.
- HOLD:
  - frame_valid=1; frame_cmd, frame_len and the buffer are stable.
  - frame_valid & frame_ready → IDLE the next cycle, with frame_valid=0 that same next cycle.
  - Incoming bytes during HOLD are dropped and pulse err_drop. No buffering; the upstream SYNC search restarts after the release.
- Abort: in CMD, LEN, PAYLOAD or CHK, either condition below pulses err_abort and → IDLE.
  - rx_endofpacket=1.
  - The timeout counter reaches TIMEOUT_CYCLES with no rx_valid.
- Timeout counter: cleared on every rx_valid and in IDLE/HOLD; saturates otherwise.
- Abort does not apply in IDLE or HOLD.
- Simultaneous rx_valid and rx_endofpacket in a frame state: the byte is processed first, then the abort applies. The result is IDLE plus err_abort, unless the byte completed the frame (→ HOLD).
- A SYNC_BYTE value inside CMD, LEN, payload or CHK is data, with no resync.
- Checksum is the 8-bit XOR over CMD, LEN and the payload bytes; SYNC is excluded.
- pl_data = buffer[pl_addr] registered each cycle. Addresses ≥ frame_len return stale contents (don't-care).
- Reset mid-frame or mid-HOLD returns to IDLE immediately with frame_valid=0. Buffer contents need no reset.
- Latency: frame_valid asserts 1 clk after the rx_valid carrying CHK.

Decomposition:
- Package uart_frame_pkg:
  - state enum (IDLE, CMD, LEN, PAYLOAD, CHK, HOLD)
  - default SYNC_BYTE
  - command-code constants shared with the dispatcher
- Sub-module uart_payload_buf: MAX_PAYLOAD×8 register file with one write port and one registered read port. It has no reset on the storage.

Test Plan:
- Good frame: A5 10 02 33 44 65 (chk=10^02^33^44=65) → frame_valid=1, frame_cmd=10, frame_len=2, pl_addr 0/1 → 33/44. Hold frame_ready=0 for 20 cycles → outputs stable; pulse ready → frame_valid=0 next cycle.
- Zero-length frame: A5 7F 00 7F → frame_valid with frame_len=0. Wrong chk A5 7F 00 7E → err_chk pulse, no frame_valid.
- Length and garbage: A5 01 11 (MAX_PAYLOAD=16) → err_len, IDLE. Leading bytes 00 FF before A5 are ignored, and the next valid frame decodes.
- Abort:
  - A5 10 03 01 then rx_endofpacket → err_abort; a following full frame decodes correctly.
  - Separately, stall TIMEOUT_CYCLES after A5 → err_abort.
- Hold drop: a second frame arrives while HOLD with ready=0 → one err_drop per byte; the first frame's data is unchanged.
- Reset mid-payload: assert rst_n=0 asynchronously → frame_valid=0 and state IDLE without a clock edge; the next frame decodes.
